// File: rtl/agc_mon_pkg.sv
// Shared definitions for the AGC monitor step controller: command encodings,
// FSM state encoding, error-flag bit positions and the monitor timepulse width.
package agc_mon_pkg;

    localparam int MT_W = 12;

    typedef enum logic [1:0] {
        OP_RUN     = 2'd0,
        OP_STOP    = 2'd1,
        OP_STEP    = 2'd2,
        OP_CLR_ERR = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_STOPPING,
        ST_HALTED,
        ST_STEP_PULSE,
        ST_STEP_WAIT
    } state_t;

    localparam int ERR_TMO   = 0;
    localparam int ERR_GOJAM = 1;
    localparam int ERR_SEQ   = 2;
    localparam int ERR_ILL   = 3;

    // Index (0 = MT01) of the highest set timepulse bit; zero when idle.
    function automatic logic [3:0] mt_index(input logic [MT_W-1:0] mt);
        mt_index = 4'd0;
        for (int i = 0; i < MT_W; i++) begin
            if (mt[i]) mt_index = 4'(i);
        end
    endfunction

endpackage

// File: rtl/agc_mon_tp_tracker.sv
// Monitor timepulse tracker: synchronises MT into the CLOCK domain, detects
// MT01 rising edges, keeps the free-running MCT count and, when built with
// MON_SEQ_CHECK_EN defined, checks the MT01..MT12 ordering.
module agc_mon_tp_tracker
    import agc_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic [MT_W-1:0]  mt,
    input  logic             gojam,
    output logic             mt01_edge,
    output logic             seq_err,
    output logic [CNT_W-1:0] mct_count
);

    logic [MT_W-1:0] mt_p0, mt_p1, mt_p2;

    // Stage p0/p1: two-flop synchroniser; stage p2: one-cycle delayed copy for edge detect
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            mt_p0 <= '0;
            mt_p1 <= '0;
            mt_p2 <= '0;
        end else begin
            mt_p0 <= mt;
            mt_p1 <= mt_p0;
            mt_p2 <= mt_p1;
        end
    end

    assign mt01_edge = mt_p1[0] & ~mt_p2[0];

    // Count every MT01 rising edge regardless of controller state; wraps naturally
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            mct_count <= '0;
        end else if (mt01_edge) begin
            mct_count <= mct_count + 1'b1;
        end
    end

`ifdef MON_SEQ_CHECK_EN
    logic       have_last;
    logic [3:0] last_idx;
    logic       new_tp;
    logic       multi_hot;
    logic [3:0] cur_idx;
    logic [3:0] exp_idx;

    always_comb begin
        new_tp    = (mt_p1 != '0) && (mt_p1 != mt_p2);
        multi_hot = (mt_p1 & (mt_p1 - {{(MT_W-1){1'b0}}, 1'b1})) != '0;
        cur_idx   = mt_index(mt_p1);
        exp_idx   = (last_idx == 4'd11) ? 4'd0 : last_idx + 4'd1;
    end

    // Flag non-one-hot pulses and out-of-order pulses; a restart forgets the previous index
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            have_last <= 1'b0;
            last_idx  <= 4'd0;
            seq_err   <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (gojam) begin
                have_last <= 1'b0;
            end else if (new_tp) begin
                if (multi_hot) begin
                    seq_err <= 1'b1;
                end else begin
                    if (have_last && (cur_idx != exp_idx)) seq_err <= 1'b1;
                    last_idx  <= cur_idx;
                    have_last <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = gojam ^ (^mt_p2[MT_W-1:1]);
    assign seq_err = 1'b0;
`endif

endmodule

// File: rtl/agc_monitor_step_ctl.sv
// AGC monitor step controller: drives the A2 timer's MSTP/MSTRTP monitor inputs
// to halt, single-step N memory cycles and resume, watching MT01 edges,
// MSTPIT_ and MGOJAM. Optional MT sequence checking is built in when the
// MON_SEQ_CHECK_EN macro is defined (see agc_mon_tp_tracker).
module agc_monitor_step_ctl
    import agc_mon_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096,
    parameter int STRT_W  = 2
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic [MT_W-1:0]  MT,
    input  logic             MSTPIT_,
    input  logic             MGOJAM,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    output logic             MSTP,
    output logic             MSTRTP,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mct_count,
    output logic [3:0]       err_flags
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int PW_W  = $clog2(STRT_W + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(STRT_W - 1);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [TMO_W-1:0] tmo_cnt;
    logic [PW_W-1:0]  pw_cnt;
    logic             mt01_edge;
    logic             seq_err;
    logic             acc;
    logic             tmo_hit;

    agc_mon_tp_tracker #(
        .CNT_W (CNT_W)
    ) u_tracker (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .mt        (MT),
        .gojam     (MGOJAM),
        .mt01_edge (mt01_edge),
        .seq_err   (seq_err),
        .mct_count (mct_count)
    );

    assign acc     = cmd_valid & cmd_ready;
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    // Control FSM: command handshake, stop/step sequencing, handshake timeouts, sticky errors
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            MSTP      <= 1'b0;
            MSTRTP    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_flags <= 4'd0;
            remaining <= '0;
            tmo_cnt   <= '0;
            pw_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            tmo_cnt <= tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;
            if (mt01_edge) tmo_cnt <= '0;
            // Clear first so that any bit set later in this cycle takes precedence
            if (acc && (cmd_op == OP_CLR_ERR)) err_flags <= 4'd0;
            if (seq_err) err_flags[ERR_SEQ] <= 1'b1;

            if (busy && MGOJAM) begin
                err_flags[ERR_GOJAM] <= 1'b1;
                state     <= ST_HALTED;
                MSTRTP    <= 1'b0;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                done      <= 1'b1;
                tmo_cnt   <= '0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (acc && (cmd_op == OP_STOP)) begin
                            state     <= ST_STOPPING;
                            MSTP      <= 1'b1;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            tmo_cnt   <= '0;
                        end else if (acc && (cmd_op == OP_STEP)) begin
                            err_flags[ERR_ILL] <= 1'b1;
                        end
                    end
                    ST_STOPPING: begin
                        if (!MSTPIT_ || tmo_hit) begin
                            if (MSTPIT_) err_flags[ERR_TMO] <= 1'b1;
                            state     <= ST_HALTED;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                            tmo_cnt   <= '0;
                        end
                    end
                    ST_HALTED: begin
                        if (acc) begin
                            case (cmd_op)
                                OP_RUN: begin
                                    state   <= ST_RUN;
                                    MSTP    <= 1'b0;
                                    tmo_cnt <= '0;
                                end
                                OP_STOP: done <= 1'b1;
                                OP_STEP: begin
                                    if (cmd_count == '0) begin
                                        done <= 1'b1;
                                    end else begin
                                        remaining <= cmd_count;
                                        state     <= ST_STEP_PULSE;
                                        MSTRTP    <= 1'b1;
                                        pw_cnt    <= '0;
                                        cmd_ready <= 1'b0;
                                        busy      <= 1'b1;
                                        tmo_cnt   <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_STEP_PULSE: begin
                        if (pw_cnt == PW_LAST) begin
                            MSTRTP  <= 1'b0;
                            state   <= ST_STEP_WAIT;
                            tmo_cnt <= '0;
                        end else begin
                            pw_cnt <= pw_cnt + 1'b1;
                        end
                    end
                    ST_STEP_WAIT: begin
                        if (mt01_edge) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == CNT_W'(1)) begin
                                state     <= ST_HALTED;
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                                done      <= 1'b1;
                            end else begin
                                state  <= ST_STEP_PULSE;
                                MSTRTP <= 1'b1;
                                pw_cnt <= '0;
                            end
                        end else if (tmo_hit) begin
                            err_flags[ERR_TMO] <= 1'b1;
                            state     <= ST_HALTED;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                            tmo_cnt   <= '0;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agc_monitor_step_ctl.sv
// Testbench for agc_monitor_step_ctl: a timer model answers MSTRTP pulses
// with MT01..MT12 sequences; expected done results are queued when a command
// is issued and compared when the DUT pulses done.
module tb_agc_monitor_step_ctl;
    import agc_mon_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int STRT_W  = 2;

    logic             CLOCK = 1'b0;
    logic             rst = 1'b1;
    logic [11:0]      MT;
    logic [11:0]      mt_model = '0;
    logic [11:0]      mt_man = '0;
    logic             MSTPIT_ = 1'b1;
    logic             MGOJAM;
    logic             gj_man = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_ready, MSTP, MSTRTP, busy, done;
    logic [CNT_W-1:0] mct_count;
    logic [3:0]       err_flags;

    assign MT = mt_model | mt_man;

    agc_monitor_step_ctl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .STRT_W  (STRT_W)
    ) dut (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .MT        (MT),
        .MSTPIT_   (MSTPIT_),
        .MGOJAM    (MGOJAM),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_ready (cmd_ready),
        .MSTP      (MSTP),
        .MSTRTP    (MSTRTP),
        .busy      (busy),
        .done      (done),
        .mct_count (mct_count),
        .err_flags (err_flags)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       err;
        logic [CNT_W-1:0] mct;
    } exp_t;

    exp_t sb[$];
    int   done_cnt = 0;

    task automatic expect_done(input logic [3:0] err, input logic [CNT_W-1:0] mct);
        exp_t e;
        e.err = err;
        e.mct = mct;
        sb.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge CLOCK) begin
        if (!rst && done) begin
            check("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("done_err", err_flags, e.err);
                check("done_mct", mct_count, e.mct);
                check("done_mstp", MSTP, 1);
                check("done_mstrtp", MSTRTP, 0);
                check("done_busy", busy, 0);
            end
            done_cnt++;
        end
    end

    // MT01 rising edges presented to the DUT
    int   mt_edges = 0;
    logic mt0_q = 1'b0;
    always @(posedge CLOCK) begin
        if (MT[0] && !mt0_q) mt_edges <= mt_edges + 1;
        mt0_q <= MT[0];
    end

    // Timer model: one MT01..MT12 sequence per MSTRTP pulse, optional restart or silence
    int npulse   = 0;
    int gojam_at = -1;
    int mt_mode  = 0;
    initial begin : timer_model
        int   phase;
        int   width;
        int   gj;
        logic strt_q;
        logic pending;
        phase = 0; width = 0; gj = 0; strt_q = 1'b0; pending = 1'b0;
        MGOJAM = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (MSTRTP) begin
                width++;
            end else if (strt_q) begin
                if (!rst) check("mstrtp_width", width, STRT_W);
                width = 0;
                npulse++;
                if (npulse == gojam_at) gj = 4;
                else if (mt_mode == 0) begin
                    if (phase == 0) phase = 1;
                    else pending = 1'b1;
                end
            end
            strt_q = MSTRTP;
            if (phase == 0 && pending) begin
                phase = 1;
                pending = 1'b0;
            end
            if (phase > 0) begin
                mt_model = 12'(1) << (phase - 1);
                phase = (phase == 12) ? 0 : phase + 1;
            end else begin
                mt_model = '0;
            end
            MGOJAM = (gj > 0) | gj_man;
            if (gj > 0) gj--;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        @(negedge CLOCK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag, output int n);
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        check({tag, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic drive_mt(input logic [11:0] v);
        mt_man = v;
        tick(2);
        mt_man = '0;
        tick(2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        int n;
        int base;

        tick(3);
        rst = 1'b0;
        tick(2);
        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_mstp", MSTP, 0);
        check("rst_mstrtp", MSTRTP, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mct", mct_count, 0);
        check("rst_err", err_flags, 0);

        // STOP with acknowledge after ~10 cycles; a command while not ready is ignored
        d0 = done_cnt;
        expect_done(4'b0000, 16'd0);
        send(OP_STOP, '0);
        check("stop_mstp", MSTP, 1);
        check("stop_ready", cmd_ready, 0);
        check("stop_busy", busy, 1);
        send(OP_STEP, 16'd5);
        tick(8);
        MSTPIT_ = 1'b0;
        wait_done(d0, 40, "stop", n);
        check("halt_ready", cmd_ready, 1);
        check("halt_err", err_flags, 0);

        // STEP 3 from HALTED
        tick(2);
        base = npulse;
        d0 = done_cnt;
        expect_done(4'b0000, 16'd3);
        send(OP_STEP, 16'd3);
        check("step_mstrtp", MSTRTP, 1);
        check("step_busy", busy, 1);
        check("step_ready", cmd_ready, 0);
        wait_done(d0, 300, "step3", n);
        check("step3_pulses", npulse - base, 3);
        tick(20);

        // STEP 5 aborted by MGOJAM during the 2nd MCT
        base = npulse;
        gojam_at = base + 2;
        d0 = done_cnt;
        expect_done(4'b0010, 16'd4);
        send(OP_STEP, 16'd5);
        wait_done(d0, 300, "gojam", n);
        check("gojam_pulses", npulse - base, 2);
        check("gojam_err", err_flags, 4'b0010);
        tick(6);
        gojam_at = -1;
        send(OP_CLR_ERR, '0);
        tick(1);
        check("clr_after_gojam", err_flags, 0);
        tick(20);

        // STEP 1 with no MT01 ever: handshake timeout
        mt_mode = 1;
        base = npulse;
        d0 = done_cnt;
        expect_done(4'b0001, 16'd4);
        send(OP_STEP, 16'd1);
        wait_done(d0, TIMEOUT + 40, "tmo", n);
        check("tmo_latency", (n >= TIMEOUT) && (n <= TIMEOUT + 8), 1);
        check("tmo_err", err_flags, 4'b0001);
        check("tmo_pulses", npulse - base, 1);
        mt_mode = 0;
        send(OP_CLR_ERR, '0);
        check("clr_after_tmo", err_flags, 0);
        check("mct_total_a", mct_count, mt_edges);

        // HALTED: STOP is a no-op with done; STEP 0 gives done without MSTRTP
        d0 = done_cnt;
        expect_done(4'b0000, 16'd4);
        send(OP_STOP, '0);
        wait_done(d0, 5, "halt_stop", n);
        base = npulse;
        d0 = done_cnt;
        expect_done(4'b0000, 16'd4);
        send(OP_STEP, '0);
        wait_done(d0, 5, "step0", n);
        tick(4);
        check("step0_pulses", npulse - base, 0);
        check("step0_mstrtp", MSTRTP, 0);

        // Resume, then illegal STEP and no-op RUN while running
        send(OP_RUN, '0);
        check("run_mstp", MSTP, 0);
        check("run_ready", cmd_ready, 1);
        MSTPIT_ = 1'b1;
        send(OP_STEP, 16'd2);
        tick(1);
        check("ill_err", err_flags, 4'b1000);
        check("ill_mstrtp", MSTRTP, 0);
        send(OP_RUN, '0);
        tick(3);
        check("run_noop_mstp", MSTP, 0);
        send(OP_CLR_ERR, '0);
        check("clr_after_ill", err_flags, 0);

`ifdef MON_SEQ_CHECK_EN
        // Sequence checker: skip, two-hot, then clean wrap after a restart
        drive_mt(12'h001);
        drive_mt(12'h004);
        tick(3);
        check("seq_skip", err_flags[2], 1);
        send(OP_CLR_ERR, '0);
        check("seq_clr1", err_flags, 0);
        drive_mt(12'h003);
        tick(3);
        check("seq_twohot", err_flags[2], 1);
        send(OP_CLR_ERR, '0);
        check("seq_clr2", err_flags, 0);
        gj_man = 1'b1;
        tick(2);
        gj_man = 1'b0;
        tick(2);
        for (int k = 9; k < 14; k++) drive_mt(12'(1) << (k % 12));
        tick(3);
        check("seq_wrap", err_flags[2], 0);
`endif
        tick(3);
        check("mct_total_b", mct_count, mt_edges);

        // Reset in the middle of a STEP
        d0 = done_cnt;
        expect_done(4'b0000, CNT_W'(mt_edges));
        send(OP_STOP, '0);
        tick(9);
        MSTPIT_ = 1'b0;
        wait_done(d0, 40, "stop2", n);
        send(OP_STEP, 16'd5);
        tick(12);
        check("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mstp", MSTP, 0);
        check("mid_rst_mstrtp", MSTRTP, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_mct", mct_count, 0);
        check("mid_rst_err", err_flags, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
